// File: rtl/counter_sweep_ctrl_pkg.sv
// Shared types and defaults for the counter sweep sequencer.
// The state encoding is fixed so that state values seen in a waveform are stable.
package counter_sweep_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam int CNT_W_DEF   = 4;
   localparam int SWEEP_W_DEF = 4;

   // Watchdog counter must be able to hold the value WDOG_MAX itself.
   function automatic int wdog_width(input int wdog_max);
      return $clog2(wdog_max + 1);
   endfunction

endpackage

// File: rtl/counter_sweep_ctrl_if.sv
// Control/status bundle between the CSR side, the sweep sequencer and the counter.
// master = CSR logic plus counter (drives requests and timeout), slave = sequencer.
interface counter_sweep_ctrl_if #(
   parameter int SWEEP_W = 4
);
   logic               start;
   logic [SWEEP_W-1:0] sweeps;
   logic               pause;
   logic               abort;
   logic               cnt_timeout;
   logic               cnt_enable;
   logic               cnt_dn_up;
   logic               busy;
   logic               done;
   logic               err;
   logic [SWEEP_W-1:0] sweeps_left;

   modport master (
      output start, sweeps, pause, abort, cnt_timeout,
      input  cnt_enable, cnt_dn_up, busy, done, err, sweeps_left
   );

   modport slave (
      input  start, sweeps, pause, abort, cnt_timeout,
      output cnt_enable, cnt_dn_up, busy, done, err, sweeps_left
   );
endinterface

// File: rtl/counter_sweep_ctrl_sweep_wdog.sv
// Per-phase watchdog: counts enabled cycles and flags the cycle in which the
// running count reaches WDOG_MAX.
module counter_sweep_ctrl_sweep_wdog
   import counter_sweep_ctrl_pkg::*;
#(
   parameter int WDOG_MAX = 18
) (
   input  logic clk,
   input  logic n_reset,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int W = wdog_width(WDOG_MAX);
   localparam logic [W-1:0] LAST = W'(WDOG_MAX - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && cnt_q != LAST + W'(1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Expiry fires on the enabled cycle that brings the count up to WDOG_MAX.
   assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer: drives the up/down counter through N round trips 0->MAX->0,
// with pause, abort and a per-phase watchdog.
module counter_sweep_ctrl
   import counter_sweep_ctrl_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEF,
   parameter int SWEEP_W  = SWEEP_W_DEF,
   parameter int WDOG_MAX = 2**CNT_W + 2
) (
   input  logic                  clk,
   input  logic                  n_reset,
   counter_sweep_ctrl_if.slave   bus
);
   state_e             state_q, state_d;
   logic [SWEEP_W-1:0] sweeps_left_q, sweeps_left_d;
   logic               err_q, err_d;
   logic               wdog_clr;
   logic               wdog_expired;
   logic               running;
   logic               enable;

   assign running = (state_q == ST_UP) || (state_q == ST_DOWN);
   // The timeout term keeps the counter parked on its terminal value for one dwell cycle.
   assign enable  = running && !bus.pause && !bus.cnt_timeout;

   counter_sweep_ctrl_sweep_wdog #(
      .WDOG_MAX (WDOG_MAX)
   ) u_wdog (
      .clk       (clk),
      .n_reset   (n_reset),
      .clr_i     (wdog_clr),
      .en_i      (enable),
      .expired_o (wdog_expired)
   );

   always_comb begin
      state_d       = state_q;
      sweeps_left_d = sweeps_left_q;
      err_d         = err_q;
      wdog_clr      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               if (bus.sweeps != '0) begin
                  state_d       = ST_UP;
                  sweeps_left_d = bus.sweeps;
                  err_d         = 1'b0;
                  wdog_clr      = 1'b1;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_UP, ST_DOWN: begin
            // abort > watchdog > timeout; pause only blocks the timeout path.
            if (bus.abort) begin
               state_d = ST_DONE;
            end else if (wdog_expired) begin
               state_d  = ST_DONE;
               err_d    = 1'b1;
               wdog_clr = 1'b1;
            end else if (bus.cnt_timeout && !bus.pause) begin
               wdog_clr = 1'b1;
               if (state_q == ST_UP) begin
                  state_d = ST_DOWN;
               end else begin
                  if (sweeps_left_q != '0) begin
                     sweeps_left_d = sweeps_left_q - SWEEP_W'(1);
                  end
                  state_d = (sweeps_left_q <= SWEEP_W'(1)) ? ST_DONE : ST_UP;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_q       <= ST_IDLE;
         sweeps_left_q <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         sweeps_left_q <= sweeps_left_d;
         err_q         <= err_d;
      end
   end

   assign bus.cnt_enable  = enable;
   assign bus.cnt_dn_up   = (state_q != ST_DOWN);
   assign bus.busy        = running;
   assign bus.done        = (state_q == ST_DONE);
   assign bus.err         = err_q;
   assign bus.sweeps_left = sweeps_left_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl driving a 4-bit up/down counter model.
// Cycle n is the interval right after edge n-1; the start request is sampled on edge 0.
module tb_counter_sweep_ctrl;
   logic       clk;
   logic       n_reset;
   logic [3:0] cnt_q;
   logic       force_to0;
   int         checks;
   int         errors;
   int         cyc;
   int         done_cyc;
   int         done_n;
   int         busy_n;
   int         en_n;

   counter_sweep_ctrl_if #(.SWEEP_W(4)) bus ();

   counter_sweep_ctrl dut (
      .clk     (clk),
      .n_reset (n_reset),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The controlled counter
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         cnt_q <= 4'd0;
      end else if (bus.cnt_enable) begin
         cnt_q <= bus.cnt_dn_up ? cnt_q + 4'd1 : cnt_q - 4'd1;
      end
   end

   assign bus.cnt_timeout = force_to0 ? 1'b0
                          : (bus.cnt_dn_up ? (cnt_q == 4'd15) : (cnt_q == 4'd0));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_obs();
      tick();
      cyc++;
      if (bus.done) begin
         done_n++;
         if (done_cyc == 0) done_cyc = cyc;
      end
      if (bus.busy) busy_n++;
      if (bus.cnt_enable) en_n++;
   endtask

   task automatic start_run(input logic [3:0] s);
      cyc = 0; done_cyc = 0; done_n = 0; busy_n = 0; en_n = 0;
      bus.start  = 1'b1;
      bus.sweeps = s;
      tick_obs();
      bus.start  = 1'b0;
      $display("run sweeps=%0d started, cycle %0d busy=%0b", s, cyc, bus.busy);
   endtask

   task automatic do_reset();
      n_reset = 1'b0;
      repeat (3) tick();
      n_reset = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed 1 expected 0");
      $fatal(1, "bench timeout");
   end

   initial begin
      checks = 0; errors = 0; force_to0 = 1'b0;
      n_reset = 1'b0;
      bus.start = 1'b0; bus.sweeps = 4'd2; bus.pause = 1'b0; bus.abort = 1'b0;

      // 1: reset held while start toggles
      for (int i = 0; i < 3; i++) begin
         bus.start = ~bus.start;
         tick();
         check("rst_done", bus.done, 0);
         check("rst_busy", bus.busy, 0);
         check("rst_en", bus.cnt_enable, 0);
         check("rst_dnup", bus.cnt_dn_up, 1);
         check("rst_err", bus.err, 0);
         check("rst_left", bus.sweeps_left, 0);
         $display("reset cycle %0d done=%0b busy=%0b", i, bus.done, bus.busy);
      end
      bus.start = 1'b0;
      n_reset = 1'b1;
      tick();
      check("rel_done", bus.done, 0);
      check("rel_busy", bus.busy, 0);

      // 2: two full sweeps from 0
      start_run(4'd2);
      check("t2_busy1", bus.busy, 1);
      check("t2_en1", bus.cnt_enable, 1);
      check("t2_left1", bus.sweeps_left, 2);
      while (cyc < 16) tick_obs();
      check("t2_cnt16", cnt_q, 15);
      check("t2_en16", bus.cnt_enable, 0);
      check("t2_dnup16", bus.cnt_dn_up, 1);
      tick_obs();
      check("t2_dnup17", bus.cnt_dn_up, 0);
      check("t2_en17", bus.cnt_enable, 1);
      while (cyc < 32) tick_obs();
      check("t2_cnt32", cnt_q, 0);
      check("t2_left32", bus.sweeps_left, 2);
      tick_obs();
      check("t2_left33", bus.sweeps_left, 1);
      check("t2_dnup33", bus.cnt_dn_up, 1);
      while (cyc < 68) tick_obs();
      check("t2_done_cyc", done_cyc, 65);
      check("t2_done_n", done_n, 1);
      check("t2_busy_n", busy_n, 64);
      check("t2_err", bus.err, 0);
      check("t2_left_end", bus.sweeps_left, 0);
      $display("t2 done at cycle %0d busy cycles %0d", done_cyc, busy_n);

      // 3: zero sweeps, plus start ignored in DONE
      start_run(4'd0);
      check("t3_done1", bus.done, 1);
      check("t3_busy1", bus.busy, 0);
      bus.start = 1'b1; bus.sweeps = 4'd2;
      tick_obs();
      bus.start = 1'b0;
      check("t3_busy2", bus.busy, 0);
      check("t3_done2", bus.done, 0);
      while (cyc < 4) tick_obs();
      check("t3_done_n", done_n, 1);
      check("t3_busy_n", busy_n, 0);
      check("t3_en_n", en_n, 0);
      $display("t3 done at cycle %0d", done_cyc);

      // 4: one sweep with 10 paused cycles in UP
      start_run(4'd1);
      while (cyc < 5) tick_obs();
      bus.pause = 1'b1;
      #1;
      check("t4_en_paused", bus.cnt_enable, 0);
      repeat (5) tick_obs();
      check("t4_cnt_mid", cnt_q, 4);
      check("t4_busy_mid", bus.busy, 1);
      repeat (5) tick_obs();
      bus.pause = 1'b0;
      check("t4_cnt15", cnt_q, 4);
      while (cyc < 46) tick_obs();
      check("t4_done_cyc", done_cyc, 43);
      check("t4_busy_n", busy_n, 42);
      $display("t4 done at cycle %0d", done_cyc);

      // 5: abort mid-DOWN of three sweeps
      start_run(4'd3);
      while (cyc < 20) tick_obs();
      check("t5_dnup20", bus.cnt_dn_up, 0);
      bus.abort = 1'b1;
      tick_obs();
      bus.abort = 1'b0;
      check("t5_done21", bus.done, 1);
      check("t5_left21", bus.sweeps_left, 3);
      check("t5_err21", bus.err, 0);
      check("t5_busy21", bus.busy, 0);
      tick_obs();
      check("t5_done22", bus.done, 0);
      check("t5_busy22", bus.busy, 0);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("t5_idle_abort_done", bus.done, 0);
      check("t5_idle_abort_busy", bus.busy, 0);
      $display("t5 abort done at cycle %0d left=%0d", done_cyc, bus.sweeps_left);
      do_reset();

      // 6: counter that never times out trips the watchdog
      force_to0 = 1'b1;
      start_run(4'd1);
      while (cyc < 22) tick_obs();
      check("t6_done_cyc", done_cyc, 19);
      check("t6_en_n", en_n, 18);
      check("t6_err", bus.err, 1);
      check("t6_left", bus.sweeps_left, 1);
      $display("t6 watchdog done at cycle %0d err=%0b", done_cyc, bus.err);
      force_to0 = 1'b0;
      start_run(4'd1);
      check("t6_err_clr", bus.err, 0);
      check("t6_busy", bus.busy, 1);
      bus.abort = 1'b1;
      tick_obs();
      bus.abort = 1'b0;
      check("t6_abort_done", bus.done, 1);
      tick();
      $display("t6 restart err=%0b", bus.err);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
